// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CSUM_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CK_HI,
    CK_LO,
    DONE
  } loader_state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream in, memory write port and CPU hold/status out.
interface mem_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);

  logic              load_start;
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data;
  logic              mem_w_en;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  modport master (
    output load_start, byte_in, byte_valid,
    input  byte_ready, mem_addr, mem_data, mem_w_en, busy, done, err, cpu_hold
  );

  modport slave (
    input  load_start, byte_in, byte_valid,
    output byte_ready, mem_addr, mem_data, mem_w_en, busy, done, err, cpu_hold
  );

endinterface

// File: rtl/loader_csum.sv
// 16-bit running sum of the words written during one load.
module loader_csum
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [CSUM_W-1:0] data_i,
  output logic [CSUM_W-1:0] sum_o
);

  logic [CSUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Boot loader: length header + big-endian words into instruction memory, CPU held until done.
// Optional trailing checksum check enabled by defining LOADER_CHECKSUM_EN.
module mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned START_ADDR = 0
)
(
  input  logic         clk,
  input  logic         reset,
  mem_loader_if.slave  bus
);

  localparam int unsigned       CAP   = (32'd1 << ADDR_W) - START_ADDR;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e POST_DATA = CK_HI;
`else
  localparam loader_state_e POST_DATA = DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              w_en_q, w_en_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;

  logic              xfer_c;
  logic              start_c;
  logic [WORD_W-1:0] rx_word_c;

  assign xfer_c    = bus.byte_valid && ready_q;
  assign start_c   = bus.load_start && !busy_q;
  assign rx_word_c = {hi_q, bus.byte_in};

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_c;

  loader_csum u_csum (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (start_c),
    .add_i   (w_en_q),
    .data_i  (data_q),
    .sum_o   (csum_c)
  );
`endif

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    w_en_d  = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_c) begin
          state_d = LEN_HI;
          addr_d  = START;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      LEN_HI: begin
        if (xfer_c) begin
          hi_d    = bus.byte_in;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer_c) begin
          cnt_d = rx_word_c;
          if (rx_word_c == '0) begin
            state_d = POST_DATA;
          end else if (32'(rx_word_c) > CAP) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (xfer_c) begin
          hi_d    = bus.byte_in;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (xfer_c) begin
          data_d  = rx_word_c;
          w_en_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = (cnt_q == LEN_W'(1)) ? POST_DATA : DATA_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      CK_HI: begin
        if (xfer_c) begin
          hi_d    = bus.byte_in;
          state_d = CK_LO;
        end
      end
      CK_LO: begin
        if (xfer_c) begin
          if (rx_word_c != csum_c) begin
            err_d = 1'b1;
          end
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Successful completion releases the CPU on entry to DONE.
    if (state_d == DONE && state_q != DONE && !err_d) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end

    ready_d = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CK_HI, CK_LO};
    busy_d  = !(state_d inside {IDLE, DONE});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= START;
      data_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      w_en_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      w_en_q  <= w_en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.mem_w_en   = w_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.cpu_hold   = hold_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader (ADDR_W=4, START_ADDR=0).
module tb_mem_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mem_loader_if #(.ADDR_W(4)) bus ();

  mem_loader #(.ADDR_W(4), .START_ADDR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [3:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [15:0] wv[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Record every write and confirm the stream is stalled while it happens.
  always @(negedge clk) begin
    if (reset && bus.mem_w_en === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
      check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
    end
  end

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // Present one byte from a negedge; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_load(input bit gaps);
    logic [15:0] n;
    logic [15:0] sum;
    n   = 16'(wv.size());
    sum = 16'h0;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (wv[i]) begin
      logic [15:0] w;
      w   = wv[i];
      sum = sum + w;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(w[15:8]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(w[7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum[15:8]);
    send_byte(sum[7:0]);
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (bus.done !== 1'b1 && bus.err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("end_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_addr"},  32'(bus.mem_addr),   32'd0);
    check({tag, "_data"},  32'(bus.mem_data),   32'd0);
    check({tag, "_wen"},   32'(bus.mem_w_en),   32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_done"},  32'(bus.done),       32'd0);
    check({tag, "_err"},   32'(bus.err),        32'd0);
    check({tag, "_hold"},  32'(bus.cpu_hold),   32'd1);
  endtask

  initial begin
    bus.load_start = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Two-word load with exact write/release latency
    pulse_start();
    check("t1_busy",  32'(bus.busy),       32'd1);
    check("t1_ready", 32'(bus.byte_ready), 32'd1);
    check("t1_hold",  32'(bus.cpu_hold),   32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    check("t1_wen",   32'(bus.mem_w_en), 32'd1);
    check("t1_addr",  32'(bus.mem_addr), 32'd1);
    check("t1_data",  32'(bus.mem_data), 32'hABCD);
    check("t1_done_early", 32'(bus.done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hBE); send_byte(8'h01);
`else
    @(negedge clk);
`endif
    check("t1_done",  32'(bus.done),       32'd1);
    check("t1_hold0", 32'(bus.cpu_hold),   32'd0);
    check("t1_err",   32'(bus.err),        32'd0);
    check("t1_busy0", 32'(bus.busy),       32'd0);
    check("t1_rdy0",  32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    check("t1_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t1_a0", 32'(wr_addr[0]), 32'd0);
      check("t1_d0", 32'(wr_data[0]), 32'h1234);
      check("t1_a1", 32'(wr_addr[1]), 32'd1);
      check("t1_d1", 32'(wr_data[1]), 32'hABCD);
    end

    // Zero-length header
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    check("t2_done_clr", 32'(bus.done),     32'd0);
    check("t2_hold",     32'(bus.cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00); send_byte(8'h00);
`endif
    check("t2_done", 32'(bus.done),     32'd1);
    check("t2_err",  32'(bus.err),      32'd0);
    check("t2_hold0",32'(bus.cpu_hold), 32'd0);
    @(negedge clk);
    check("t2_nwr", 32'(wr_addr.size()), 32'd0);

    // 17 words overflows a 16-word memory
    pulse_start();
    send_byte(8'h00); send_byte(8'h11);
    check("t3_err",   32'(bus.err),        32'd1);
    check("t3_done",  32'(bus.done),       32'd0);
    check("t3_hold",  32'(bus.cpu_hold),   32'd1);
    check("t3_busy",  32'(bus.busy),       32'd0);
    check("t3_ready", 32'(bus.byte_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("t3_nwr", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    check("t3_err_clr", 32'(bus.err),      32'd0);
    check("t3_hold1",   32'(bus.cpu_hold), 32'd1);
    check("t3_busy1",   32'(bus.busy),     32'd1);

    // Exactly 16 words fills memory; address wraps back to 0 afterwards
    wv.delete();
    for (int i = 0; i < 16; i++) wv.push_back(16'hC000 | 16'(i));
    send_load(1'b0);
    wait_end();
    check("t3b_err",  32'(bus.err),      32'd0);
    check("t3b_done", 32'(bus.done),     32'd1);
    check("t3b_addr", 32'(bus.mem_addr), 32'd0);
    check("t3b_nwr",  32'(wr_addr.size()), 32'd16);
    if (wr_addr.size() == 16) begin
      check("t3b_alast", 32'(wr_addr[15]), 32'd15);
      check("t3b_dlast", 32'(wr_data[15]), 32'hC00F);
      check("t3b_a7",    32'(wr_addr[7]),  32'd7);
      check("t3b_d7",    32'(wr_data[7]),  32'hC007);
    end

    // Random valid gaps while loading 3 words
    wr_addr.delete(); wr_data.delete();
    wv.delete();
    wv.push_back(16'h0102); wv.push_back(16'hFFEE); wv.push_back(16'h8001);
    pulse_start();
    send_load(1'b1);
    wait_end();
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_nwr",  32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      check("t4_a0", 32'(wr_addr[0]), 32'd0);
      check("t4_d0", 32'(wr_data[0]), 32'h0102);
      check("t4_a1", 32'(wr_addr[1]), 32'd1);
      check("t4_d1", 32'(wr_data[1]), 32'hFFEE);
      check("t4_a2", 32'(wr_addr[2]), 32'd2);
      check("t4_d2", 32'(wr_data[2]), 32'h8001);
    end

    // Reset after the first of four words
    pulse_start();
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h77); send_byte(8'h88);
    check("t5_wen", 32'(bus.mem_w_en), 32'd1);
    @(negedge clk);
    check("t5_addr_pre", 32'(bus.mem_addr), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    wr_addr.delete(); wr_data.delete();
    wv.delete();
    wv.push_back(16'h5A5A);
    pulse_start();
    send_load(1'b0);
    wait_end();
    check("t5_done", 32'(bus.done), 32'd1);
    check("t5_nwr",  32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("t5_a0", 32'(wr_addr[0]), 32'd0);
      check("t5_d0", 32'(wr_data[0]), 32'h5A5A);
    end

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum keeps the CPU held
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'hBE); send_byte(8'h02);
    check("t6_err",  32'(bus.err),      32'd1);
    check("t6_done", 32'(bus.done),     32'd0);
    check("t6_hold", 32'(bus.cpu_hold), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Boot-time program loader for the 16-bit CPU. It accepts a byte stream (length header, then instruction words high byte first) and writes each assembled word into instruction memory through a memory write port. It holds the CPU idle until the load completes, then releases it so the fetch/decode FSM starts from a populated memory. It is the writer side of the memory that the decode FSM reads opcodes from.

## Interface
Parameters:
- ADDR_W, 10, memory address width in words
- START_ADDR, 0, first word address written

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- load_start  input  1  single-cycle request to begin a load
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader can accept a byte this cycle
- mem_addr  output  ADDR_W  write address
- mem_data  output  16  write data
- mem_w_en  output  1  memory write strobe, one cycle per word
- busy  output  1  load in progress (any state except IDLE and DONE)
- done  output  1  level; load finished without error
- err  output  1  level; load rejected (length overflow, or checksum mismatch)
- cpu_hold  output  1  high keeps the CPU's PC and register enables inactive

## Operation
- A byte transfers when byte_valid && byte_ready. Bytes presented while byte_ready is low are not consumed.
- States:
  - IDLE: waits for load_start, then goes to LEN_HI.
  - LEN_HI, LEN_LO: capture the 16-bit word count N, high byte first.
  - DATA_HI, DATA_LO: assemble one word, high byte first.
  - WRITE: issues the memory write.
  - CK_HI, CK_LO: receive the checksum; present only with the checksum option.
  - DONE: terminal state for both success and error.
- Leaving LEN_LO:
  - N == 0: go to DONE, or to CK_HI with the checksum option.
  - N > 2^ADDR_W − START_ADDR: set err and go to DONE. No writes occur.
  - Otherwise: go to DATA_HI.
- WRITE lasts one cycle.
  - Outputs: mem_w_en=1, mem_addr=current address, mem_data=assembled word.
  - Next cycle: the address increments and the remaining count decrements.
  - When the remaining count reaches 0, go to DONE (or CK_HI). Otherwise go back to DATA_HI.
- DONE:
  - done=1 if err=0.
  - cpu_hold=0 only if err=0.
  - A new load_start clears done and err, sets cpu_hold=1, reloads the address to START_ADDR, and goes to LEN_HI.
- load_start is ignored while busy.
- Address arithmetic is modulo 2^ADDR_W. The overflow check guarantees no wrap within a single load.

## Timing
- Reset values: byte_ready=0, mem_addr=START_ADDR, mem_data=0, mem_w_en=0, busy=0, done=0, err=0, cpu_hold=1. State is IDLE.
- Reset mid-load aborts immediately. Memory already written is left as is, and cpu_hold returns to 1.
- byte_ready is registered.
  - It is 1 in LEN_*, DATA_* and CK_*.
  - It is 0 in IDLE, WRITE and DONE.
- Throughput is 3 cycles per word at a continuous byte rate.
- Latency:
  - The last data byte accepted in cycle t gives mem_w_en in cycle t+1.
  - The same byte gives done/cpu_hold release in cycle t+2 when no checksum is configured.
- mem_addr and mem_data are stable throughout the mem_w_en cycle.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the data words, two bytes (high first) carry the 16-bit sum of all data words modulo 2^16.
  - On mismatch, set err, keep cpu_hold=1, and go to DONE.
  - On match, done=1.
- LOADER_CHECKSUM_EN undefined:
  - CK_* states and the accumulator are absent.
  - After the last WRITE the loader goes straight to DONE.

## Structure
- Shared package loader_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CK_HI, CK_LO, DONE)
  - the width constant for the header length field (16)
  - the checksum width (16)
- Natural sub-module: loader_csum, a 16-bit running-sum accumulator.
  - It clears on load_start, adds on mem_w_en, and exposes the sum.
  - It is instantiated only under LOADER_CHECKSUM_EN.

## Test plan
- Reset, then load_start, then bytes 00 02 12 34 AB CD → writes 0x1234 at address 0 and 0xABCD at address 1. done=1 and cpu_hold=0 two cycles after the last byte.
- Header 00 00 → no mem_w_en. DONE is reached and done=1.
- With ADDR_W=4 and START_ADDR=0, header 00 11 (17 words) → err=1, cpu_hold=1, zero writes. The next load_start clears err.
- byte_valid toggled 1-0-1 at random while loading 3 words → identical writes and addresses. No byte is lost or duplicated, and byte_ready=0 during WRITE.
- Reset asserted after the first of 4 words → outputs return to reset values. A new load of 1 word writes at START_ADDR.
- LOADER_CHECKSUM_EN with words 0x1234 and 0xABCD:
  - checksum BE 01 → done=1
  - checksum BE 02 → err=1, cpu_hold=1
